// File: rtl/varredura_updown.sv
`default_nettype none
// ============================================================================
//  Module   : varredura_updown
//  Purpose  : Position-sweep generator (triangle or sawtooth) between runtime
//             limits, one step per D qualified conta ticks.
//  Revision : 1.0  initial release
// ============================================================================
module varredura_updown #(
    parameter int N = 3,
    parameter int D = 1
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    input  logic         pausa,
    input  logic         modo,
    input  logic [N-1:0] limite_min,
    input  logic [N-1:0] limite_max,
    output logic [N-1:0] value,
    output logic         direcao,
    output logic         fim,
    output logic         meio
);

    localparam int CW = $clog2(D) + 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(D - 1);
    localparam logic [0:0]    c_st_down  = 1'b0;
    localparam logic [0:0]    c_st_up    = 1'b1;

    logic [0:0]   r_state, w_state_nxt;
    logic [N-1:0] r_value, w_value_nxt;
    logic [CW-1:0] r_cnt,  w_cnt_nxt;
    logic         r_fim,   w_fim_nxt;
    logic         r_meio,  w_meio_nxt;

    logic         w_tick;
    logic [N:0]   w_val_x, w_min_x, w_max_x, w_val_inc, w_min_inc;

    assign w_tick    = conta & ~pausa;
    // One extra bit so value+1 and min+1 never wrap in the limit compares
    assign w_val_x   = {1'b0, r_value};
    assign w_min_x   = {1'b0, limite_min};
    assign w_max_x   = {1'b0, limite_max};
    assign w_val_inc = w_val_x + (N+1)'(1);
    assign w_min_inc = w_min_x + (N+1)'(1);

    always_ff @(posedge clock) begin
        if (zera_s) begin
            r_state <= c_st_up;
            r_value <= limite_min;
            r_cnt   <= '0;
            r_fim   <= 1'b0;
            r_meio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fim   <= w_fim_nxt;
            r_meio  <= w_meio_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_cnt_nxt   = r_cnt;
        w_fim_nxt   = 1'b0;
        w_meio_nxt  = 1'b0;
        if (w_tick) begin
            if (r_cnt != c_cnt_last) begin
                w_cnt_nxt = r_cnt + CW'(1);
            end else begin
                w_cnt_nxt = '0;
                if (w_max_x <= w_min_x) begin
                    w_value_nxt = limite_min;
                    w_state_nxt = c_st_up;
                end else if (modo) begin
                    // Sawtooth always rises, even if entered while falling
                    w_state_nxt = c_st_up;
                    if (w_val_x >= w_max_x) begin
                        w_value_nxt = limite_min;
                        w_fim_nxt   = 1'b1;
                    end else begin
                        w_value_nxt = w_val_inc[N-1:0];
                        w_meio_nxt  = (w_val_inc == w_max_x);
                    end
                end else begin
                    case (r_state)
                        c_st_up: begin
                            if (w_val_inc >= w_max_x) begin
                                w_value_nxt = limite_max;
                                w_meio_nxt  = 1'b1;
                                w_state_nxt = c_st_down;
                            end else begin
                                w_value_nxt = w_val_inc[N-1:0];
                            end
                        end
                        default: begin
                            if (w_val_x <= w_min_inc) begin
                                w_value_nxt = limite_min;
                                w_fim_nxt   = 1'b1;
                                w_state_nxt = c_st_up;
                            end else begin
                                w_value_nxt = r_value - N'(1);
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        value   = r_value;
        direcao = r_state[0];
        fim     = r_fim;
        meio    = r_meio;
    end

endmodule
`default_nettype wire

// File: tb/tb_varredura_updown.sv
`default_nettype none
// ============================================================================
//  Module   : tb_varredura_updown
//  Purpose  : Directed self-checking bench for varredura_updown (D=1 and D=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_varredura_updown;

    logic       clock = 1'b0;
    logic       zera_s, conta, pausa, modo;
    logic [2:0] limite_min, limite_max;
    logic [2:0] value,  value3;
    logic       direcao, fim, meio;
    logic       direcao3, fim3, meio3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    varredura_updown #(.N(3), .D(1)) dut (
        .clock(clock), .zera_s(zera_s), .conta(conta), .pausa(pausa), .modo(modo),
        .limite_min(limite_min), .limite_max(limite_max),
        .value(value), .direcao(direcao), .fim(fim), .meio(meio)
    );

    varredura_updown #(.N(3), .D(3)) dut3 (
        .clock(clock), .zera_s(zera_s), .conta(conta), .pausa(pausa), .modo(modo),
        .limite_min(limite_min), .limite_max(limite_max),
        .value(value3), .direcao(direcao3), .fim(fim3), .meio(meio3)
    );

    task automatic step_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] mn, input logic [2:0] mx, input logic md);
        limite_min = mn; limite_max = mx; modo = md;
        zera_s = 1'b1; conta = 1'b0; pausa = 1'b0;
        step_clk();
        zera_s = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd0, 3'd7, 1'b0);
        checks++;
        if ({value, direcao, fim, meio} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got v=%0d d=%0b f=%0b m=%0b want v=0 d=1 f=0 m=0",
                     value, direcao, fim, meio);
        end
    endtask

    // 0..7..0 twice: meio at steps 7,21; fim at steps 14,28
    task automatic test_triangle();
        int m;
        logic [2:0] ev;
        logic ed, ef, em;
        do_reset(3'd0, 3'd7, 1'b0);
        conta = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step_clk();
            m  = k % 14;
            ev = (m <= 7) ? 3'(m) : 3'(14 - m);
            ed = (m >= 1 && m <= 6) || (m == 0);
            ef = (m == 0);
            em = (m == 7);
            checks++;
            if ({value, direcao, fim, meio} !== {ev, ed, ef, em}) begin
                errors++;
                $display("FAIL triangle step %0d: got v=%0d d=%0b f=%0b m=%0b want v=%0d d=%0b f=%0b m=%0b",
                         k, value, direcao, fim, meio, ev, ed, ef, em);
            end
        end
        conta = 1'b0;
    endtask

    task automatic test_dwell();
        logic [2:0] ev;
        do_reset(3'd0, 3'd7, 1'b0);
        conta = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            step_clk();
            ev = 3'(t / 3);
            checks++;
            if (value3 !== ev) begin
                errors++;
                $display("FAIL dwell tick %0d: got v=%0d want v=%0d", t, value3, ev);
            end
        end
        conta = 1'b0;
    endtask

    task automatic test_sawtooth();
        logic [2:0] exp_v [8] = '{3'd3, 3'd4, 3'd5, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
        logic ef, em;
        do_reset(3'd2, 3'd5, 1'b1);
        conta = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step_clk();
            em = (exp_v[k] == 3'd5);
            ef = (exp_v[k] == 3'd2);
            checks++;
            if ({value, direcao, fim, meio} !== {exp_v[k], 1'b1, ef, em}) begin
                errors++;
                $display("FAIL sawtooth step %0d: got v=%0d d=%0b f=%0b m=%0b want v=%0d d=1 f=%0b m=%0b",
                         k, value, direcao, fim, meio, exp_v[k], ef, em);
            end
        end
        conta = 1'b0;
    endtask

    task automatic test_pause();
        do_reset(3'd0, 3'd7, 1'b0);
        conta = 1'b1;
        repeat (4) step_clk();
        pausa = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_clk();
            checks++;
            if ({value, direcao, fim, meio, value3} !== {3'd4, 1'b1, 1'b0, 1'b0, 3'd1}) begin
                errors++;
                $display("FAIL pause cycle %0d: got v=%0d d=%0b f=%0b m=%0b v3=%0d want v=4 d=1 f=0 m=0 v3=1",
                         k, value, direcao, fim, meio, value3);
            end
        end
        pausa = 1'b0;
        step_clk();
        checks++;
        if ({value, value3} !== {3'd5, 3'd1}) begin
            errors++;
            $display("FAIL pause resume1: got v=%0d v3=%0d want v=5 v3=1", value, value3);
        end
        step_clk();
        checks++;
        if (value3 !== 3'd2) begin
            errors++;
            $display("FAIL pause resume2: got v3=%0d want v3=2", value3);
        end
        conta = 1'b0;
    endtask

    task automatic test_limit_change();
        logic [2:0] exp_v [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        logic [2:0] exp_d [4] = '{3'd0, 3'd0, 3'd0, 3'd1};
        do_reset(3'd0, 3'd7, 1'b0);
        conta = 1'b1;
        repeat (6) step_clk();
        limite_max = 3'd3;
        for (int k = 0; k < 4; k++) begin
            step_clk();
            checks++;
            if ({value, direcao, fim, meio} !== {exp_v[k], exp_d[k][0], (k == 3), (k == 0)}) begin
                errors++;
                $display("FAIL limit_change step %0d: got v=%0d d=%0b f=%0b m=%0b want v=%0d d=%0b f=%0b m=%0b",
                         k, value, direcao, fim, meio, exp_v[k], exp_d[k][0], (k == 3), (k == 0));
            end
        end
        conta = 1'b0;
    endtask

    task automatic test_reset_midsweep();
        do_reset(3'd1, 3'd7, 1'b0);
        conta = 1'b1;
        repeat (4) step_clk();
        checks++;
        if (value !== 3'd5) begin
            errors++;
            $display("FAIL midsweep pre: got v=%0d want v=5", value);
        end
        zera_s = 1'b1;
        step_clk();
        checks++;
        if ({value, direcao, fim, meio} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midsweep reset: got v=%0d d=%0b f=%0b m=%0b want v=1 d=1 f=0 m=0",
                     value, direcao, fim, meio);
        end
        zera_s = 1'b0;
        limite_min = 3'd4;
        limite_max = 3'd4;
        for (int k = 0; k < 3; k++) begin
            step_clk();
            checks++;
            if ({value, direcao, fim, meio} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL degenerate step %0d: got v=%0d d=%0b f=%0b m=%0b want v=4 d=1 f=0 m=0",
                         k, value, direcao, fim, meio);
            end
        end
        conta = 1'b0;
    endtask

    initial begin
        zera_s = 1'b1; conta = 1'b0; pausa = 1'b0; modo = 1'b0;
        limite_min = 3'd0; limite_max = 3'd7;
        test_reset();
        test_triangle();
        test_dwell();
        test_sawtooth();
        test_pause();
        test_limit_change();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
